ds1302_time_sequencer: RTL and testbench
========================================

# ds1302_time_sequencer

Command sequencer between the user logic (keypad / CLCD / FND) and the DS1302 serial engine. It polls the seconds, minutes and hours registers on a fixed period and publishes them as BCD. On request it writes a new time: it clears write-protect, then writes seconds, minutes and hours. It drives the engine's addr/data/valid inputs and consumes its busy and received-byte outputs.

## Interface
Parameters:
- POLL_DIV, 5_000_000: clk cycles between poll sequences (50 ms at 100 MHz).
- BUSY_TIMEOUT, 2_000_000: max clk cycles spent in any single wait state before abort.

Ports:
- clk  in  1  system clock.
- reset_p  in  1  reset, asynchronous, active-high.
- i_set  in  1  one-cycle request to write the time.
- i_set_hour  in  6  BCD hour, 24 h format, 00–23.
- i_set_min  in  7  BCD minute.
- i_set_sec  in  7  BCD second.
- o_addr  out  8  command byte to the engine.
- o_data  out  8  write data to the engine.
- o_valid  out  1  transaction request to the engine.
- i_busy  in  1  engine busy. Asynchronous to clk; the engine runs on a divided clock.
- i_receive  in  8  byte read by the engine; stable while i_busy is low.
- o_hour  out  6  BCD hour.
- o_min  out  7  BCD minute.
- o_sec  out  7  BCD second.
- o_time_valid  out  1  one-cycle pulse after a complete read sequence.
- o_seq_busy  out  1  high while any sequence is in progress.
- o_error  out  1  sticky timeout flag; cleared by reset or by the next successful sequence.

## Operation
- i_busy passes through a 2-flop synchronizer. Rise and fall edges are detected on the synchronized signal.
- Read sequence: 0x81 (seconds), 0x83 (minutes), 0x85 (hours). o_data = 0x00.
- Write sequence: 0x8E/0x00 (WP off), 0x80/{0,sec}, 0x82/{0,min}, 0x84/{00,hour}. The hours byte has bit7=0, selecting 24 h mode.
- Set values are latched on i_set.
- State machine:
  - IDLE → ISSUE when a request is pending.
  - ISSUE: o_valid=1 and addr/data driven. On busy rise, go to WAIT_DONE.
  - WAIT_DONE: o_valid=0. On busy fall, go to CAPTURE.
  - CAPTURE: for read commands, store the byte. Increment the step index. Go to ISSUE if steps remain, else DONE.
  - DONE: pulse o_time_valid (read sequence only) and clear o_error. Go to IDLE.
- Capture masks:
  - o_sec ← receive[6:0] (CH bit dropped).
  - o_min ← receive[6:0].
  - o_hour ← receive[5:0].
  - Published registers update together in DONE, never partially.
- The poll counter counts 0..POLL_DIV-1 free-running. The wrap sets poll_pending.
- An i_set pulse sets set_pending and latches the values. A new i_set while set_pending is high overwrites the latched values.
- Priority in IDLE: set_pending before poll_pending. If both set in the same cycle, the write runs first and the poll runs next.
- A request arriving mid-sequence stays pending; the current sequence is never preempted.
- Timeout: a per-state counter runs in ISSUE and WAIT_DONE. On reaching BUSY_TIMEOUT:
  - o_valid=0 and o_error=1.
  - The sequence is abandoned and published values are unchanged.
  - The state returns to IDLE. The pending flag of the aborted sequence is cleared.

## Timing
- Reset values: o_addr=0, o_data=0, o_valid=0, o_hour/o_min/o_sec=0, o_time_valid=0, o_seq_busy=0, o_error=0. All counters and pending flags are 0.
- Reset is asynchronous: o_valid drops immediately, including mid-transaction.
- o_valid and o_addr/o_data are registered. They are valid the cycle after ISSUE is entered and held until busy rise is seen.
- Edge detection latency is 3 clk cycles from a raw i_busy transition: 2 synchronizer stages plus 1 edge register.
- o_valid falls 1 cycle after the detected rise. i_receive is sampled 1 cycle after the detected fall.
- o_time_valid pulses 1 cycle after the final capture. o_hour/o_min/o_sec change in that same cycle.
- o_seq_busy rises 1 cycle after leaving IDLE and falls on the return to IDLE.
- If i_busy is already high on entering ISSUE, wait for its fall, then a new rise. Never accept a stale transaction.

## Configuration
- DS1302_CH_CLEAR_EN defined:
  - In CAPTURE of the seconds read, if receive[7]=1 (oscillator halted), set set_pending.
  - The latched values become {receive[6:0], current o_min, current o_hour}.
  - The chip is restarted with CH=0 after the poll completes.
- Undefined: the CH bit is ignored; only masking applies.

## Test plan
- Engine model: busy rises 10 cycles after o_valid and lasts 200 cycles. Polled reads of receive 0x45, 0x59, 0x23 → addr order 0x81, 0x83, 0x85; o_sec=0x45, o_min=0x59, o_hour=0x23; one o_time_valid pulse.
- i_set with 12:34:56 → writes 0x8E/0x00, 0x80/0x56, 0x82/0x34, 0x84/0x12 in order; no o_time_valid.
- i_set coincident with a poll wrap → the write sequence completes first, then the read sequence; exactly 7 transactions.
- Engine never raises busy (BUSY_TIMEOUT=1000) → o_valid low after 1000 cycles, o_error=1, outputs unchanged; the next successful poll clears o_error.
- Assert reset_p during WAIT_DONE → o_valid and all outputs 0 within the same cycle; a normal poll follows reset release.
- With DS1302_CH_CLEAR_EN, seconds read 0x97 → o_sec=0x17, followed by a write sequence with 0x80/0x17.

Source files
------------

// File: rtl/ds1302_time_sequencer.sv
// DS1302 command sequencer: periodic seconds/minutes/hours poll and on-demand time write.
// Optional feature macro DS1302_CH_CLEAR_EN: a halted oscillator (CH=1) triggers a restart write.
module ds1302_time_sequencer #(
   parameter int unsigned POLL_DIV     = 5_000_000,
   parameter int unsigned BUSY_TIMEOUT = 2_000_000
) (
   input  logic       clk,
   input  logic       reset_p,
   input  logic       i_set,
   input  logic [5:0] i_set_hour,
   input  logic [6:0] i_set_min,
   input  logic [6:0] i_set_sec,
   output logic [7:0] o_addr,
   output logic [7:0] o_data,
   output logic       o_valid,
   input  logic       i_busy,
   input  logic [7:0] i_receive,
   output logic [5:0] o_hour,
   output logic [6:0] o_min,
   output logic [6:0] o_sec,
   output logic       o_time_valid,
   output logic       o_seq_busy,
   output logic       o_error
);

   localparam int unsigned PollW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int unsigned ToW   = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [PollW-1:0] PollLast = PollW'(POLL_DIV - 1);
   localparam logic [ToW-1:0]   ToLast   = ToW'(BUSY_TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitDone,
      StCapture,
      StDone
   } state_e;

   state_e           state_q, state_d;
   logic             busy_s1_q, busy_s2_q, busy_s3_q;
   logic             busy_rise, busy_fall;
   logic [1:0]       step_q, step_d, last_step;
   logic             is_write_q, is_write_d;
   logic [PollW-1:0] poll_cnt_q, poll_cnt_d;
   logic             poll_wrap;
   logic             poll_pend_q, poll_pend_d;
   logic             set_pend_q, set_pend_d;
   logic [5:0]       set_hour_q, set_hour_d;
   logic [6:0]       set_min_q, set_min_d;
   logic [6:0]       set_sec_q, set_sec_d;
   logic [ToW-1:0]   to_cnt_q, to_cnt_d;
   logic             timeout, abort;
   logic [6:0]       sh_sec_q, sh_sec_d;
   logic [6:0]       sh_min_q, sh_min_d;
   logic [5:0]       sh_hour_q, sh_hour_d;
   logic [7:0]       cmd_addr, cmd_data;
   logic [7:0]       addr_q, addr_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic [5:0]       hour_q, hour_d;
   logic [6:0]       min_q, min_d;
   logic [6:0]       sec_q, sec_d;
   logic             tv_q, tv_d;
   logic             seq_busy_q, seq_busy_d;
   logic             error_q, error_d;

   assign busy_rise = busy_s2_q & ~busy_s3_q;
   assign busy_fall = ~busy_s2_q & busy_s3_q;
   assign poll_wrap = (poll_cnt_q == PollLast);
   assign timeout   = (to_cnt_q == ToLast);
   assign last_step = is_write_q ? 2'd3 : 2'd2;

`ifndef DS1302_CH_CLEAR_EN
   logic unused_rx_ch;
   assign unused_rx_ch = i_receive[7];
`endif

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      is_write_d  = is_write_q;
      poll_cnt_d  = poll_wrap ? '0 : poll_cnt_q + PollW'(1);
      poll_pend_d = poll_pend_q | poll_wrap;
      set_pend_d  = set_pend_q;
      set_hour_d  = set_hour_q;
      set_min_d   = set_min_q;
      set_sec_d   = set_sec_q;
      to_cnt_d    = '0;
      abort       = 1'b0;
      sh_sec_d    = sh_sec_q;
      sh_min_d    = sh_min_q;
      sh_hour_d   = sh_hour_q;
      hour_d      = hour_q;
      min_d       = min_q;
      sec_d       = sec_q;
      tv_d        = 1'b0;
      error_d     = error_q;

      unique case (state_q)
         StIdle: begin
            if (set_pend_q) begin
               state_d    = StIssue;
               is_write_d = 1'b1;
               step_d     = 2'd0;
               set_pend_d = 1'b0;
            end else if (poll_pend_q) begin
               state_d     = StIssue;
               is_write_d  = 1'b0;
               step_d      = 2'd0;
               poll_pend_d = poll_wrap;
            end
         end
         // Only a fresh rise counts, so a busy already high on entry is waited out.
         StIssue: begin
            if (busy_rise) begin
               state_d = StWaitDone;
            end else if (timeout) begin
               abort = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + ToW'(1);
            end
         end
         StWaitDone: begin
            if (busy_fall) begin
               state_d = StCapture;
            end else if (timeout) begin
               abort = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + ToW'(1);
            end
         end
         StCapture: begin
            if (!is_write_q) begin
               case (step_q)
                  2'd0: begin
                     sh_sec_d = i_receive[6:0];
`ifdef DS1302_CH_CLEAR_EN
                     if (i_receive[7]) begin
                        set_pend_d = 1'b1;
                        set_sec_d  = i_receive[6:0];
                        set_min_d  = min_q;
                        set_hour_d = hour_q;
                     end
`endif
                  end
                  2'd1:    sh_min_d  = i_receive[6:0];
                  default: sh_hour_d = i_receive[5:0];
               endcase
            end
            if (step_q == last_step) begin
               state_d = StDone;
            end else begin
               step_d  = step_q + 2'd1;
               state_d = StIssue;
            end
         end
         StDone: begin
            if (!is_write_q) begin
               sec_d  = sh_sec_q;
               min_d  = sh_min_q;
               hour_d = sh_hour_q;
               tv_d   = 1'b1;
            end
            error_d = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (abort) begin
         state_d = StIdle;
         error_d = 1'b1;
         if (is_write_q) begin
            set_pend_d = 1'b0;
         end else begin
            poll_pend_d = poll_wrap;
         end
      end

      if (i_set) begin
         set_pend_d = 1'b1;
         set_hour_d = i_set_hour;
         set_min_d  = i_set_min;
         set_sec_d  = i_set_sec;
      end
   end

   always_comb begin
      cmd_addr = 8'h81;
      cmd_data = 8'h00;
      if (is_write_d) begin
         case (step_d)
            2'd0: cmd_addr = 8'h8E;
            2'd1: begin
               cmd_addr = 8'h80;
               cmd_data = {1'b0, set_sec_q};
            end
            2'd2: begin
               cmd_addr = 8'h82;
               cmd_data = {1'b0, set_min_q};
            end
            default: begin
               cmd_addr = 8'h84;
               cmd_data = {2'b00, set_hour_q};
            end
         endcase
      end else begin
         case (step_d)
            2'd0:    cmd_addr = 8'h81;
            2'd1:    cmd_addr = 8'h83;
            default: cmd_addr = 8'h85;
         endcase
      end

      addr_d = addr_q;
      data_d = data_q;
      if ((state_d == StIssue) && (state_q != StIssue)) begin
         addr_d = cmd_addr;
         data_d = cmd_data;
      end
      valid_d    = (state_d == StIssue);
      seq_busy_d = (state_q != StIdle) && (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         busy_s1_q   <= 1'b0;
         busy_s2_q   <= 1'b0;
         busy_s3_q   <= 1'b0;
         state_q     <= StIdle;
         step_q      <= 2'd0;
         is_write_q  <= 1'b0;
         poll_cnt_q  <= '0;
         poll_pend_q <= 1'b0;
         set_pend_q  <= 1'b0;
         set_hour_q  <= '0;
         set_min_q   <= '0;
         set_sec_q   <= '0;
         to_cnt_q    <= '0;
         sh_sec_q    <= '0;
         sh_min_q    <= '0;
         sh_hour_q   <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         hour_q      <= '0;
         min_q       <= '0;
         sec_q       <= '0;
         tv_q        <= 1'b0;
         seq_busy_q  <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         busy_s1_q   <= i_busy;
         busy_s2_q   <= busy_s1_q;
         busy_s3_q   <= busy_s2_q;
         state_q     <= state_d;
         step_q      <= step_d;
         is_write_q  <= is_write_d;
         poll_cnt_q  <= poll_cnt_d;
         poll_pend_q <= poll_pend_d;
         set_pend_q  <= set_pend_d;
         set_hour_q  <= set_hour_d;
         set_min_q   <= set_min_d;
         set_sec_q   <= set_sec_d;
         to_cnt_q    <= to_cnt_d;
         sh_sec_q    <= sh_sec_d;
         sh_min_q    <= sh_min_d;
         sh_hour_q   <= sh_hour_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         hour_q      <= hour_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         tv_q        <= tv_d;
         seq_busy_q  <= seq_busy_d;
         error_q     <= error_d;
      end
   end

   assign o_addr       = addr_q;
   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_hour       = hour_q;
   assign o_min        = min_q;
   assign o_sec        = sec_q;
   assign o_time_valid = tv_q;
   assign o_seq_busy   = seq_busy_q;
   assign o_error      = error_q;

endmodule

// File: tb/tb_ds1302_time_sequencer.sv
// Self-checking bench: behavioural DS1302 engine/chip model with randomized latency and data.
`timescale 1ns/1ps
module tb_ds1302_time_sequencer;

   localparam int unsigned POLL_DIV     = 3000;
   localparam int unsigned BUSY_TIMEOUT = 1000;

   logic       clk = 1'b0;
   logic       reset_p = 1'b1;
   logic       i_set = 1'b0;
   logic [5:0] i_set_hour = '0;
   logic [6:0] i_set_min = '0;
   logic [6:0] i_set_sec = '0;
   logic [7:0] o_addr, o_data;
   logic       o_valid;
   logic       i_busy = 1'b0;
   logic [7:0] i_receive = '0;
   logic [5:0] o_hour;
   logic [6:0] o_min, o_sec;
   logic       o_time_valid, o_seq_busy, o_error;

   always #5 clk = ~clk;

   ds1302_time_sequencer #(
      .POLL_DIV    (POLL_DIV),
      .BUSY_TIMEOUT(BUSY_TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset_p     (reset_p),
      .i_set       (i_set),
      .i_set_hour  (i_set_hour),
      .i_set_min   (i_set_min),
      .i_set_sec   (i_set_sec),
      .o_addr      (o_addr),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_busy      (i_busy),
      .i_receive   (i_receive),
      .o_hour      (o_hour),
      .o_min       (o_min),
      .o_sec       (o_sec),
      .o_time_valid(o_time_valid),
      .o_seq_busy  (o_seq_busy),
      .o_error     (o_error)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Engine / chip model controls (written by main only).
   bit         eng_en = 1'b1;
   int         dly_min = 10, dly_max = 10, len_min = 200, len_max = 200;
   logic [7:0] pre_sec = '0, pre_min = '0, pre_hour = '0;
   int         pre_gen = 0;

   // Transaction log (written by the engine only).
   logic [7:0] log_addr[$];
   logic [7:0] log_data[$];
   logic [7:0] chip_sec = '0, chip_min = '0, chip_hour = '0;

   initial begin : engine
      logic [7:0] a, d;
      int dly, len, seen_gen;
      seen_gen = 0;
      forever begin
         @(negedge clk);
         if (pre_gen != seen_gen) begin
            chip_sec  = pre_sec;
            chip_min  = pre_min;
            chip_hour = pre_hour;
            seen_gen  = pre_gen;
         end
         if (eng_en && o_valid && !i_busy && !reset_p) begin
            a = o_addr;
            d = o_data;
            log_addr.push_back(a);
            log_data.push_back(d);
            dly = $urandom_range(dly_max, dly_min);
            len = $urandom_range(len_max, len_min);
            repeat (dly) @(posedge clk);
            #3;
            case (a)
               8'h81:   i_receive = chip_sec;
               8'h83:   i_receive = chip_min;
               8'h85:   i_receive = chip_hour;
               8'h80:   chip_sec = d;
               8'h82:   chip_min = d;
               8'h84:   chip_hour = d;
               default: ;
            endcase
            i_busy = 1'b1;
            repeat (len) @(posedge clk);
            #3 i_busy = 1'b0;
         end
      end
   end

   int tv_cnt = 0;
   always @(negedge clk) if (o_time_valid) tv_cnt <= tv_cnt + 1;

   // Reference model: raw chip contents and the published registers the DUT should show.
   logic [7:0] mdl_sec = '0, mdl_min = '0, mdl_hour = '0;
   logic [6:0] pub_sec = '0, pub_min = '0;
   logic [5:0] pub_hour = '0;
   logic [7:0] exp_a[$];
   logic [7:0] exp_d[$];

   function automatic logic [7:0] bcd(input int v);
      return 8'(((v / 10) << 4) | (v % 10));
   endfunction

   task automatic set_chip(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h);
      mdl_sec  = s;
      mdl_min  = m;
      mdl_hour = h;
      pre_sec  = s;
      pre_min  = m;
      pre_hour = h;
      pre_gen++;
      repeat (2) @(negedge clk);
   endtask

   task automatic exp_read();
      exp_a.push_back(8'h81); exp_d.push_back(8'h00);
      exp_a.push_back(8'h83); exp_d.push_back(8'h00);
      exp_a.push_back(8'h85); exp_d.push_back(8'h00);
   endtask

   task automatic exp_write(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
      exp_a.push_back(8'h8E); exp_d.push_back(8'h00);
      exp_a.push_back(8'h80); exp_d.push_back({1'b0, s});
      exp_a.push_back(8'h82); exp_d.push_back({1'b0, m});
      exp_a.push_back(8'h84); exp_d.push_back({2'b00, h});
   endtask

   task automatic publish_model();
      pub_sec  = mdl_sec[6:0];
      pub_min  = mdl_min[6:0];
      pub_hour = mdl_hour[5:0];
   endtask

   task automatic check_pub(input string tag);
      check_eq({tag, "_sec"}, o_sec, pub_sec);
      check_eq({tag, "_min"}, o_min, pub_min);
      check_eq({tag, "_hour"}, o_hour, pub_hour);
   endtask

   task automatic check_log(input string tag, input int base);
      int got_n;
      got_n = log_addr.size() - base;
      check_eq({tag, "_ntx"}, got_n, exp_a.size());
      for (int i = 0; i < exp_a.size(); i++) begin
         if (i < got_n) begin
            check_eq($sformatf("%s_addr%0d", tag, i), log_addr[base+i], exp_a[i]);
            check_eq($sformatf("%s_data%0d", tag, i), log_data[base+i], exp_d[i]);
         end
      end
   endtask

   task automatic wait_tv(input string tag, input int budget, input int tv0);
      int n;
      n = 0;
      while (tv_cnt == tv0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_tv_seen"}, (tv_cnt != tv0), 1);
      n = 0;
      while (o_seq_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_seq_done(input string tag);
      int n;
      bit ok;
      ok = 1'b1;
      n = 0;
      while (!o_seq_busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!o_seq_busy) ok = 1'b0;
      n = 0;
      while (o_seq_busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (o_seq_busy) ok = 1'b0;
      check_eq({tag, "_seq_done"}, ok, 1);
      repeat (4) @(negedge clk);
   endtask

   task automatic poll_check(input string tag);
      int base, tv0;
      base = log_addr.size();
      tv0  = tv_cnt;
      exp_a.delete();
      exp_d.delete();
      exp_read();
      wait_tv(tag, POLL_DIV + 1000, tv0);
      publish_model();
      check_log(tag, base);
      check_pub(tag);
      check_eq({tag, "_tv_count"}, tv_cnt - tv0, 1);
      check_eq({tag, "_error"}, o_error, 0);
   endtask

   task automatic do_write(input string tag, input logic [5:0] h, input logic [6:0] m,
                           input logic [6:0] s);
      int base, tv0;
      base = log_addr.size();
      tv0  = tv_cnt;
      exp_a.delete();
      exp_d.delete();
      exp_write(h, m, s);
      @(negedge clk);
      i_set = 1'b1;
      i_set_hour = h;
      i_set_min = m;
      i_set_sec = s;
      @(negedge clk);
      i_set = 1'b0;
      wait_seq_done(tag);
      check_log(tag, base);
      check_eq({tag, "_no_tv"}, tv_cnt - tv0, 0);
      check_eq({tag, "_pub_kept_sec"}, o_sec, pub_sec);
      mdl_sec  = {1'b0, s};
      mdl_min  = {1'b0, m};
      mdl_hour = {2'b00, h};
   endtask

   initial begin : watchdog
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [7:0] s, m, h;
      logic [6:0] ws, wm;
      logic [5:0] wh;
      int base, tv0, n, dur;
      bit wrote;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_addr", o_addr, 0);
      check_eq("rst_data", o_data, 0);
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_hour", o_hour, 0);
      check_eq("rst_min", o_min, 0);
      check_eq("rst_sec", o_sec, 0);
      check_eq("rst_tv", o_time_valid, 0);
      check_eq("rst_seq_busy", o_seq_busy, 0);
      check_eq("rst_error", o_error, 0);
      reset_p = 1'b0;

      // Directed poll with fixed engine timing.
      set_chip(8'h45, 8'h59, 8'h23);
      poll_check("poll_a");

      dly_min = 3; dly_max = 15; len_min = 20; len_max = 200;
      wrote = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (!wrote) begin
`ifdef DS1302_CH_CLEAR_EN
            s = bcd($urandom_range(59, 0));
`else
            s = {1'($urandom_range(1, 0)), bcd($urandom_range(59, 0))[6:0]};
`endif
            m = {1'($urandom_range(1, 0)), bcd($urandom_range(59, 0))[6:0]};
            h = {2'($urandom_range(3, 0)), bcd($urandom_range(23, 0))[5:0]};
            set_chip(s, m, h);
         end
         poll_check($sformatf("poll_r%0d", k));
         if (k >= 2 && k < 5) begin
            if (k == 2) begin
               wh = 6'h12; wm = 7'h34; ws = 7'h56;
            end else begin
               wh = bcd($urandom_range(23, 0))[5:0];
               wm = bcd($urandom_range(59, 0))[6:0];
               ws = bcd($urandom_range(59, 0))[6:0];
            end
            do_write($sformatf("write_%0d", k), wh, wm, ws);
            wrote = 1'b1;
         end else begin
            wrote = 1'b0;
         end
      end

      // Engine never answers: o_valid must drop after exactly BUSY_TIMEOUT cycles.
      eng_en = 1'b0;
      n = 0;
      while (!o_valid && n < POLL_DIV + 200) begin
         @(negedge clk);
         n++;
      end
      dur = 0;
      while (o_valid && dur < BUSY_TIMEOUT + 50) begin
         @(negedge clk);
         dur++;
      end
      check_eq("timeout_valid_cycles", dur, BUSY_TIMEOUT);
      repeat (3) @(negedge clk);
      check_eq("timeout_valid_low", o_valid, 0);
      check_eq("timeout_error", o_error, 1);
      check_eq("timeout_seq_busy", o_seq_busy, 0);
      check_pub("timeout_pub");
      eng_en = 1'b1;
      poll_check("poll_after_timeout");

      // Asynchronous reset while the DUT waits for busy to fall.
      set_chip(bcd($urandom_range(59, 1)), bcd($urandom_range(59, 1)),
               bcd($urandom_range(23, 1)));
      n = 0;
      while (!i_busy && n < POLL_DIV + 200) begin
         @(negedge clk);
         n++;
      end
      repeat (6) @(posedge clk);
      #2;
      check_eq("pre_rst_seq_busy", o_seq_busy, 1);
      check_eq("pre_rst_valid", o_valid, 0);
      reset_p = 1'b1;
      #1;
      check_eq("mid_rst_valid", o_valid, 0);
      check_eq("mid_rst_addr", o_addr, 0);
      check_eq("mid_rst_sec", o_sec, 0);
      check_eq("mid_rst_min", o_min, 0);
      check_eq("mid_rst_hour", o_hour, 0);
      check_eq("mid_rst_seq_busy", o_seq_busy, 0);
      check_eq("mid_rst_error", o_error, 0);
      pub_sec = '0; pub_min = '0; pub_hour = '0;
      n = 0;
      while (i_busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      reset_p = 1'b0;
      poll_check("poll_after_reset");

      // i_set coincident with the poll wrap: write first, then read.
      wh = bcd($urandom_range(23, 0))[5:0];
      wm = bcd($urandom_range(59, 0))[6:0];
      ws = bcd($urandom_range(59, 0))[6:0];
      @(negedge clk);
      reset_p = 1'b1;
      @(negedge clk);
      reset_p = 1'b0;
      pub_sec = '0; pub_min = '0; pub_hour = '0;
      base = log_addr.size();
      tv0 = tv_cnt;
      repeat (POLL_DIV - 1) @(posedge clk);
      #1;
      i_set = 1'b1;
      i_set_hour = wh;
      i_set_min = wm;
      i_set_sec = ws;
      @(posedge clk);
      #1;
      i_set = 1'b0;
      exp_a.delete();
      exp_d.delete();
      exp_write(wh, wm, ws);
      exp_read();
      wait_tv("coinc", 3000, tv0);
      mdl_sec = {1'b0, ws}; mdl_min = {1'b0, wm}; mdl_hour = {2'b00, wh};
      publish_model();
      check_log("coinc", base);
      check_pub("coinc");
      check_eq("coinc_tv_count", tv_cnt - tv0, 1);

`ifdef DS1302_CH_CLEAR_EN
      // Halted oscillator: seconds read with CH=1 triggers a restart write.
      set_chip(8'h97, mdl_min, mdl_hour);
      base = log_addr.size();
      tv0 = tv_cnt;
      exp_a.delete();
      exp_d.delete();
      exp_read();
      exp_write(pub_hour, pub_min, 7'h17);
      wait_tv("ch_clear", POLL_DIV + 1000, tv0);
      wait_seq_done("ch_clear_write");
      publish_model();
      check_log("ch_clear", base);
      check_pub("ch_clear");
      check_eq("ch_clear_tv_count", tv_cnt - tv0, 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
